// File: rtl/if_id_fetch_queue_pkg.sv
// Shared fetch-path defines plus the fetch-queue package: word width, depth and the
// occupancy classification used to derive in_ready/out_valid from the registered count.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef FETCHQ_DEPTH
`define FETCHQ_DEPTH 2
`endif
`ifndef NOP_INSTR
`define NOP_INSTR 0
`endif

package if_id_fetch_queue_pkg;

    localparam int unsigned WordLen     = `WORD_LEN;
    localparam int unsigned FetchqDepth = `FETCHQ_DEPTH;
    localparam logic [WordLen-1:0] NopInstr = WordLen'(`NOP_INSTR);

    typedef enum logic [1:0] {
        OccEmpty,
        OccPartial,
        OccFull
    } occ_e;

    function automatic occ_e occ_decode(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0) begin
            return OccEmpty;
        end else if (cnt == depth) begin
            return OccFull;
        end else begin
            return OccPartial;
        end
    endfunction

endpackage

// File: rtl/fetchq_mem.sv
// Fetch-queue storage: Depth x Width register array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module fetchq_mem #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: small FIFO of {PC, instruction} pairs between fetch and decode.
// ~in_ready_o is the fetch freeze; flush discards held and same-cycle traffic.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int unsigned WORD_LEN = WordLen,
    parameter int unsigned DEPTH    = FetchqDepth,
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    input  logic [WORD_LEN-1:0] in_pc_i,
    input  logic [WORD_LEN-1:0] in_instr_i,
    input  logic                flush_i,
    input  logic                out_ready_i,
    output logic                in_ready_o,
    output logic                out_valid_o,
    output logic [WORD_LEN-1:0] out_pc_o,
    output logic [WORD_LEN-1:0] out_instr_o,
    output logic [CNT_W-1:0]    count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;
    occ_e                  occ;
    logic [2*WORD_LEN-1:0] rdata;

    // Handshakes depend only on registered count, never combinationally on out_ready_i.
    assign occ         = occ_decode(32'(count_q), DEPTH);
    assign in_ready_o  = (occ != OccFull);
    assign out_valid_o = (occ != OccEmpty);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetchq_mem #(
        .Width (2 * WORD_LEN),
        .Depth (DEPTH),
        .AddrW (PtrW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push & ~flush_i),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_pc_i, in_instr_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Empty queue presents PC 0 and a NOP so stale storage never leaks to decode.
    assign out_pc_o    = out_valid_o ? rdata[2*WORD_LEN-1:WORD_LEN] : '0;
    assign out_instr_o = out_valid_o ? rdata[WORD_LEN-1:0] : NopInstr;
    assign count_o     = count_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_if_id_fetch_queue;
    import if_id_fetch_queue_pkg::*;

    localparam int unsigned W  = WordLen;
    localparam int unsigned D  = 2;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [W-1:0]  in_pc_i = '0;
    logic [W-1:0]  in_instr_i = '0;
    logic          flush_i = 1'b0;
    logic          out_ready_i = 1'b0;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [W-1:0]  out_pc_o;
    logic [W-1:0]  out_instr_o;
    logic [CW-1:0] count_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] model_q[$];

    always #5 clk_i = ~clk_i;

    if_id_fetch_queue #(
        .WORD_LEN (W),
        .DEPTH    (D),
        .CNT_W    (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_pc_i     (in_pc_i),
        .in_instr_i  (in_instr_i),
        .flush_i     (flush_i),
        .out_ready_i (out_ready_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_pc_o    (out_pc_o),
        .out_instr_o (out_instr_o),
        .count_o     (count_o)
    );

    // Drives one cycle, advances the reference model over the edge, samples 1ns later.
    task automatic drive(input logic v, input logic [W-1:0] pc, input logic [W-1:0] ins,
                         input logic fl, input logic rdy);
        logic push, pop;
        in_valid_i  = v;
        in_pc_i     = pc;
        in_instr_i  = ins;
        flush_i     = fl;
        out_ready_i = rdy;
        push = v && (model_q.size() != int'(D));
        pop  = rdy && (model_q.size() != 0);
        @(posedge clk_i);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back({pc, ins});
        end
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || count_o !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: out_valid=%b count=%0d, required 0/0", out_valid_o, count_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_q.delete();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid_o);
        end
        n_checks++;
        if (out_instr_o !== 16'h0000 || out_pc_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: pc=%h instr=%h, required 0000/0000", out_pc_o, out_instr_o);
        end
        n_checks++;
        if (count_o !== 2'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d, required 0", count_o);
        end
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready_o);
        end
    endtask

    task automatic test_fill_drain();
        drive(1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 16'h2222, 1'b0, 1'b0);
        n_checks++;
        if (count_o !== 2'd2 || in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: count=%0d in_ready=%b, required 2/0", count_o, in_ready_o);
        end
        n_checks++;
        if (out_instr_o !== 16'h1111) begin
            n_fail++; $display("FAIL drain_first: instr=%h, required 1111", out_instr_o);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++;
        if (out_instr_o !== 16'h2222 || out_pc_o !== 16'h0002) begin
            n_fail++;
            $display("FAIL drain_second: pc=%h instr=%h, required 0002/2222", out_pc_o, out_instr_o);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++;
        if (out_valid_o !== 1'b0 || out_instr_o !== 16'h0000 || count_o !== 2'd0) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%b instr=%h count=%0d, required 0/0000/0",
                     out_valid_o, out_instr_o, count_o);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] pc;
            pc = W'(2 * i);
            drive(1'b1, pc, 16'hA000 | pc, 1'b0, 1'b1);
            n_checks++;
            if (count_o !== 2'd1 || out_pc_o !== pc || out_instr_o !== (16'hA000 | pc)) begin
                n_fail++;
                $display("FAIL stream_%0d: count=%0d pc=%h instr=%h, required 1/%h/%h",
                         i, count_o, out_pc_o, out_instr_o, pc, 16'hA000 | pc);
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_full_pop();
        drive(1'b1, 16'h0010, 16'h3333, 1'b0, 1'b0);
        drive(1'b1, 16'h0012, 16'h4444, 1'b0, 1'b0);
        drive(1'b1, 16'h0004, 16'h5555, 1'b0, 1'b1);
        n_checks++;
        if (count_o !== 2'd1 || out_pc_o !== 16'h0012) begin
            n_fail++;
            $display("FAIL full_pop_blocked: count=%0d pc=%h, required 1/0012", count_o, out_pc_o);
        end
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_pop_ready: got %b, required 1", in_ready_o);
        end
        drive(1'b1, 16'h0004, 16'h5555, 1'b0, 1'b0);
        n_checks++;
        if (count_o !== 2'd2) begin
            n_fail++; $display("FAIL full_pop_retry: count=%0d, required 2", count_o);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++;
        if (out_pc_o !== 16'h0004 || out_instr_o !== 16'h5555) begin
            n_fail++;
            $display("FAIL full_pop_order: pc=%h instr=%h, required 0004/5555", out_pc_o, out_instr_o);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h0020, 16'h6666, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, 16'h7777, 1'b0, 1'b0);
        drive(1'b1, 16'h0008, 16'h8888, 1'b1, 1'b1);
        n_checks++;
        if (count_o !== 2'd0 || out_valid_o !== 1'b0 || out_instr_o !== 16'h0000 ||
            in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: count=%0d valid=%b instr=%h ready=%b, required 0/0/0000/1",
                     count_o, out_valid_o, out_instr_o, in_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            n_checks++;
            if (out_valid_o !== 1'b0 || out_pc_o === 16'h0008) begin
                n_fail++;
                $display("FAIL flush_leak_%0d: valid=%b pc=%h, required 0/0000", i, out_valid_o, out_pc_o);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'h0030, 16'h9999, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || count_o !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b count=%0d, required 0/0", out_valid_o, count_o);
        end
        #2;
        rst_ni = 1'b1;
        model_q.delete();
        drive(1'b1, 16'h0040, 16'hBBBB, 1'b0, 1'b0);
        n_checks++;
        if (count_o !== 2'd1 || out_pc_o !== 16'h0040 || out_instr_o !== 16'hBBBB) begin
            n_fail++;
            $display("FAIL async_resume: count=%0d pc=%h instr=%h, required 1/0040/bbbb",
                     count_o, out_pc_o, out_instr_o);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] exp_pc, exp_instr;
            drive(1'($urandom_range(1)), W'($urandom), W'($urandom),
                  ($urandom_range(15) == 0), ($urandom_range(2) != 0));
            exp_pc    = (model_q.size() != 0) ? model_q[0][2*W-1:W] : '0;
            exp_instr = (model_q.size() != 0) ? model_q[0][W-1:0] : '0;
            n_checks++;
            if (int'(count_o) != model_q.size()) begin
                n_fail++;
                $display("FAIL rand_count_%0d: got %0d, required %0d", i, count_o, model_q.size());
            end
            n_checks++;
            if (in_ready_o !== (model_q.size() != int'(D)) ||
                out_valid_o !== (model_q.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_flags_%0d: ready=%b valid=%b with model size %0d",
                         i, in_ready_o, out_valid_o, model_q.size());
            end
            n_checks++;
            if (out_pc_o !== exp_pc || out_instr_o !== exp_instr) begin
                n_fail++;
                $display("FAIL rand_head_%0d: pc=%h instr=%h, required %h/%h",
                         i, out_pc_o, out_instr_o, exp_pc, exp_instr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
